// File: rtl/image_streamer.sv
// Frame buffer for one IMG_H x IMG_W image, loaded row-major by a host port and
// streamed out column-major as a gap-free pixel stream for the conv layer.
module image_streamer #(
  parameter int IMG_H  = 28,
  parameter int IMG_W  = 28,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic [DATA_W-1:0] pixel_out,
  output logic              pixel_valid,
  output logic              col_last,
  output logic              frame_done
);

  localparam int DEPTH = IMG_H * IMG_W;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  localparam logic [RW-1:0]     ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0]     COL_LAST = CW'(IMG_W - 1);
  localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_LAST
  } state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              valid_q, valid_d;
  logic              col_last_q, col_last_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] pix_q;
  logic              wr_ok;
  logic              rd_en;

  logic [DATA_W-1:0] mem [DEPTH];

  assign wr_ok = wr_en && (state_q == S_IDLE) && ({1'b0, wr_addr} < DEPTH_A);
  assign rd_en = (state_q == S_RUN);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  // The RAM read register doubles as the output register, so pixel_out is
  // forced to zero on every cycle that no read was issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_q <= '0;
    end else if (rd_en) begin
      pix_q <= mem[rd_addr_q];
    end else begin
      pix_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      rd_addr_q  <= '0;
      valid_q    <= 1'b0;
      col_last_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      rd_addr_q  <= rd_addr_d;
      valid_q    <= valid_d;
      col_last_q <= col_last_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    rd_addr_d  = rd_addr_q;
    valid_d    = 1'b0;
    col_last_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          row_d     = '0;
          col_d     = '0;
          rd_addr_d = '0;
        end
      end
      S_RUN: begin
        valid_d    = 1'b1;
        col_last_d = (row_q == ROW_LAST);
        done_d     = (row_q == ROW_LAST) && (col_q == COL_LAST);
        if (row_q == ROW_LAST) begin
          row_d = '0;
          if (col_q == COL_LAST) begin
            col_d     = '0;
            rd_addr_d = '0;
            state_d   = S_LAST;
          end else begin
            // column wrap: address restarts at the top of the next column
            col_d     = col_q + 1'b1;
            rd_addr_d = ADDR_W'(col_q) + 1'b1;
          end
        end else begin
          row_d     = row_q + 1'b1;
          rd_addr_d = rd_addr_q + ROW_STEP;
        end
      end
      S_LAST: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign pixel_out   = pix_q;
  assign pixel_valid = valid_q;
  assign col_last    = col_last_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_image_streamer.sv
// Directed bench for image_streamer: loads frames, captures whole streams and
// compares them against a small reference image held in the bench.
module tb_image_streamer;

  localparam int H = 28;
  localparam int W = 28;
  localparam int N = H * W;
  localparam int CAP = 1600;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic        busy;
  logic [15:0] pixel_out;
  logic        pixel_valid;
  logic        col_last;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] model [N];
  logic [15:0] cap_d [CAP];
  logic        cap_v [CAP];
  logic        cap_b [CAP];
  logic        cap_cl[CAP];
  logic        cap_fd[CAP];

  image_streamer #(.IMG_H(H), .IMG_W(W), .DATA_W(16), .ADDR_W(10)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .busy       (busy),
    .pixel_out  (pixel_out),
    .pixel_valid(pixel_valid),
    .col_last   (col_last),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_pix(input int n);
    return model[(n % H) * W + n / H];
  endfunction

  // Single idle-time host write; the reference image follows the accept rule.
  task automatic host_wr(input int a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = 10'(a);
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (a < N) model[a] = d;
  endtask

  // Starts a frame at the next edge (edge k) and records outputs after edges
  // k+0 .. k+ncyc-1. Optional start pulses and one busy-time write are injected.
  task automatic run_frame(input int p1, input int p2, input int wr_at, input int ncyc);
    start = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      cap_d[c]  = pixel_out;
      cap_v[c]  = pixel_valid;
      cap_b[c]  = busy;
      cap_cl[c] = col_last;
      cap_fd[c] = frame_done;
      start   = (c == p1) || (c == p2);
      wr_en   = (c == wr_at);
      wr_addr = 10'd5;
      wr_data = 16'h7FFF;
    end
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int off);
    int e_v = 0, e_b = 0, e_d = 0, e_cl = 0, e_fd = 0, e_z = 0;
    for (int c = 0; c <= N + 1; c++) begin
      int  i;
      bit  xv;
      i  = off + c;
      xv = (c >= 1) && (c <= N);
      if (cap_v[i] !== xv) e_v++;
      if (cap_b[i] !== (c <= N)) e_b++;
      if (xv) begin
        if (cap_d[i] !== exp_pix(c - 1)) e_d++;
        if (cap_cl[i] !== (((c - 1) % H) == H - 1)) e_cl++;
        if (cap_fd[i] !== (c == N)) e_fd++;
      end else begin
        if (cap_d[i] !== 16'h0) e_z++;
        if (cap_cl[i] !== 1'b0) e_cl++;
        if (cap_fd[i] !== 1'b0) e_fd++;
      end
    end
    chk({tag, "_valid_errs"}, e_v, 0);
    chk({tag, "_busy_errs"}, e_b, 0);
    chk({tag, "_data_errs"}, e_d, 0);
    chk({tag, "_col_last_errs"}, e_cl, 0);
    chk({tag, "_frame_done_errs"}, e_fd, 0);
    chk({tag, "_idle_zero_errs"}, e_z, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    chk("rst_busy", busy, 0);
    chk("rst_valid", pixel_valid, 0);
    chk("rst_col_last", col_last, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_pixel_out", pixel_out, 0);

    // Ramp image: mem[a] = a
    for (int a = 0; a < N; a++) host_wr(a, 16'(a));
    run_frame(-1, -1, -1, 800);
    check_frame("ramp", 0);
    chk("ramp_px0", cap_d[1], 16'd0);
    chk("ramp_px1", cap_d[2], 16'd28);
    chk("ramp_px27", cap_d[28], 16'd756);
    chk("ramp_px28", cap_d[29], 16'd1);
    chk("ramp_px783", cap_d[784], 16'd783);
    chk("ramp_busy_k", cap_b[0], 1);
    chk("ramp_busy_end", cap_b[785], 0);

    // Write while busy must be dropped
    run_frame(-1, -1, 400, 800);
    run_frame(-1, -1, -1, 800);
    check_frame("busy_wr", 0);
    chk("busy_wr_px140", cap_d[141], 16'd5);

    // Start in the final valid cycle is ignored; the next-cycle start runs
    run_frame(N, N + 1, -1, CAP);
    check_frame("restart_a", 0);
    check_frame("restart_b", N + 2);
    chk("restart_busy_gap", cap_b[N + 1], 0);
    chk("restart_valid_gap", cap_v[N + 2], 0);
    chk("restart_first_valid", cap_v[N + 3], 1);
    chk("restart_first_px", cap_d[N + 3], 16'd0);

    // All-zero image; out-of-range write must not alias anywhere
    for (int a = 0; a < N; a++) host_wr(a, 16'h0);
    host_wr(N, 16'hAAAA);
    run_frame(-1, -1, -1, 800);
    check_frame("zeros", 0);

    // Signed corner pixels
    host_wr(0, 16'hEC94);
    host_wr(N - 1, 16'h004F);
    run_frame(-1, -1, -1, 800);
    check_frame("signed", 0);
    chk("signed_px0", cap_d[1], 16'hEC94);
    chk("signed_px783", cap_d[784], 16'h004F);

    // Abort mid-frame with async reset
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (300) @(negedge clk);
    chk("abort_pre_valid", pixel_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_valid", pixel_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_frame_done", frame_done, 0);
    chk("abort_pixel_out", pixel_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_idle_busy", busy, 0);
    run_frame(-1, -1, -1, 800);
    check_frame("post_abort", 0);
    chk("post_abort_px0", cap_d[1], 16'hEC94);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
